sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Client-side initiator for the SDRAM controller's strobe interface (`rd`/`wr`/`rfsh`, `a`, `d`, `q`, `ready`).
- Merges a video read port, a CPU read/write port and an internal refresh timer into strobe sequences with fixed timing.
- Captures read data at a fixed latency and returns a one-cycle ack to the owning client.
- Sits between the machine core and the controller on the same clock.

Parameters:
- STROBE, 2: cycles a `rd`/`wr`/`rfsh` strobe is held high.
- DATA_LAT, 6: slot cycle index at which `sdram_q` is captured for reads.
- SLOT, 8: total cycles per transaction slot. Must satisfy SLOT > DATA_LAT > STROBE+2.
- RFSH_PERIOD, 390: cycles between refresh requests (7.8 us at 50 MHz).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- sdram_ready  in  1  controller initialised.
- sdram_rd  out  1  read strobe; controller acts on rising edge.
- sdram_wr  out  1  write strobe; controller acts on rising edge.
- sdram_rfsh  out  1  refresh strobe; controller acts on falling edge.
- sdram_a  out  25  address to controller.
- sdram_d  out  16  write data to controller.
- sdram_q  in  16  read data from controller.
- vid_req  in  1  video read request, level.
- vid_a  in  25  video address.
- vid_q  out  16  video read data.
- vid_ack  out  1  one-cycle completion pulse.
- cpu_req  in  1  CPU request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_a  in  25  CPU address.
- cpu_d  in  16  CPU write data.
- cpu_q  out  16  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- rfsh_ovf  out  1  sticky flag: a refresh tick arrived while a refresh was still pending.

Behaviour:
- Reset (asynchronous, `reset`=0):
  - state IDLE, slot counter 0, refresh timer 0, pending 0.
  - All strobes 0; `sdram_a`=0, `sdram_d`=0.
  - `vid_q`=`cpu_q`=0; both acks 0; `rfsh_ovf`=0.
  - Strobes fall immediately. A transaction in progress is abandoned with no ack.
- Refresh timer:
  - Free-running 0..RFSH_PERIOD-1 from reset; on wrap it sets pending.
  - If pending is already 1 on a wrap, `rfsh_ovf` is set and pending stays 1. Missed refreshes are not counted.
  - Pending clears on the cycle a refresh slot is granted.
- States: IDLE, BUSY.
- IDLE:
  - No grant while `sdram_ready`=0.
  - Otherwise fixed priority: pending refresh > `vid_req` > `cpu_req`.
  - A port whose ack is high this cycle is masked from grant.
  - On grant: latch owner and op; drive `sdram_a` from the owner's address and `sdram_d` from `cpu_d` (CPU write); counter <= 0; go to BUSY.
  - `sdram_a` and `sdram_d` hold until the next grant.
- BUSY (counter c = 0..SLOT-1, advances by 1 each cycle):
  - The selected strobe is high for c in [0, STROBE-1], low otherwise. The first strobe cycle is the cycle after the grant edge.
  - Refresh: `sdram_rfsh` high for STROBE cycles then low; the falling edge triggers the controller.
  - Read (video or CPU): at c==DATA_LAT, register `sdram_q` into the owner's q output. q is held until that owner's next read.
  - At c==SLOT-1: go to IDLE and register the owner's ack high for exactly one cycle. Refresh slots produce no ack.
- Client rules:
  - Hold req and operands stable from assertion until ack.
  - Deassert req after seeing ack, or keep it high to request again; re-grant happens no earlier than the second IDLE cycle.
  - Operand changes during BUSY are ignored (latched at grant).
- `sdram_ready` falling during BUSY: the slot runs to completion and acks normally; no new grants until ready returns.
- Throughput: one transaction per SLOT+1 cycles minimum.

Decomposition:
- Shared package/include holds:
  - owner encoding (NONE, RFSH, VID, CPU);
  - state encoding;
  - default timing constants STROBE, DATA_LAT, SLOT, RFSH_PERIOD.
- Natural sub-module: `sdram_rfsh_timer` (period counter, pending flag, ovf flag, clear input).
- Grant logic and slot sequencer stay in the top module.

Test Plan:
- Reset release with `sdram_ready`=0 and `cpu_req`=1 → no strobe activity. Raise ready → `sdram_rd` high 2 cycles starting one cycle after grant; `cpu_ack` pulses 8 cycles after the first strobe cycle.
- CPU write, `cpu_a`=25'h0012345, `cpu_d`=16'hBEEF → `sdram_wr` high 2 cycles; `sdram_a`/`sdram_d` carry those values for the whole slot; `cpu_ack` once; `cpu_q` unchanged.
- Video read with model returning 16'hA55A at c=DATA_LAT → `vid_q`=16'hA55A on the following cycle; `vid_ack` single pulse; `cpu_q` untouched.
- `vid_req`, `cpu_req` and refresh pending asserted together → order: refresh slot (rfsh high 2 then falls, no ack), then video, then CPU; `cpu_req` held high throughout.
- Controller model holds ready low for 3×RFSH_PERIOD → pending stays 1, `rfsh_ovf`=1 after the second wrap. On ready, exactly one refresh slot is issued first.
- Assert reset at c=1 of a CPU read → `sdram_rd` drops asynchronously; no `cpu_ack`; after release the state is IDLE and the request is re-granted from c=0.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM strobe-interface arbiter: owner and state
// encodings, bus widths and the default slot/refresh timing constants.
package sdram_arbiter_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 16;

  // Default timing: strobe width, read-capture cycle, slot length, refresh period
  localparam int unsigned STROBE_DFLT      = 2;
  localparam int unsigned DATA_LAT_DFLT    = 6;
  localparam int unsigned SLOT_DFLT        = 8;
  localparam int unsigned RFSH_PERIOD_DFLT = 390;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RFSH,
    OWN_VID,
    OWN_CPU
  } owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the arbiter, its two clients and the SDRAM controller.
//   master : arbiter side (drives strobes, address/data, client q/ack, rfsh_ovf)
//   slave  : controller + clients side (drives ready, q, requests and operands)
interface sdram_arbiter_if;
  import sdram_arbiter_pkg::*;

  logic              sdram_ready;
  logic              sdram_rd;
  logic              sdram_wr;
  logic              sdram_rfsh;
  logic [ADDR_W-1:0] sdram_a;
  logic [DATA_W-1:0] sdram_d;
  logic [DATA_W-1:0] sdram_q;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_a;
  logic [DATA_W-1:0] vid_q;
  logic              vid_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_d;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_ack;

  logic              rfsh_ovf;

  modport master (
    input  sdram_ready, sdram_q, vid_req, vid_a, cpu_req, cpu_we, cpu_a, cpu_d,
    output sdram_rd, sdram_wr, sdram_rfsh, sdram_a, sdram_d,
           vid_q, vid_ack, cpu_q, cpu_ack, rfsh_ovf
  );

  modport slave (
    output sdram_ready, sdram_q, vid_req, vid_a, cpu_req, cpu_we, cpu_a, cpu_d,
    input  sdram_rd, sdram_wr, sdram_rfsh, sdram_a, sdram_d,
           vid_q, vid_ack, cpu_q, cpu_ack, rfsh_ovf
  );

endinterface

// File: rtl/sdram_rfsh_timer.sv
// Free-running refresh period timer.
//   clock, reset : system clock, async active-low reset
//   clr          : refresh slot granted this cycle, consumes the pending tick
//   pending      : a refresh tick is waiting to be served
//   ovf          : sticky, a tick arrived while the previous one was unserved
module sdram_rfsh_timer
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned PERIOD = RFSH_PERIOD_DFLT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic pending,
  output logic ovf
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          ovf_q, ovf_d;
  logic          wrap;

  always_comb begin
    wrap      = (cnt_q == CW'(PERIOD - 1));
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (wrap) begin
      // Missed ticks collapse into one; a grant on the same edge consumes the old tick
      if (pending_q && !clr) ovf_d = 1'b1;
      pending_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates refresh, video reads and CPU reads/writes onto the SDRAM
// controller strobe interface using fixed-length transaction slots.
//   clock : system clock, all logic on posedge
//   reset : asynchronous active-low reset
//   bus   : controller strobes/address/data plus video and CPU client ports
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned STROBE      = STROBE_DFLT,
  parameter int unsigned DATA_LAT    = DATA_LAT_DFLT,
  parameter int unsigned SLOT        = SLOT_DFLT,
  parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DFLT
) (
  input  logic            clock,
  input  logic            reset,
  sdram_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d, wr_q, wr_d, rfsh_q, rfsh_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] vid_q_q, vid_q_d, cpu_q_q, cpu_q_d;
  logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;

  logic rfsh_pend, rfsh_clr, rfsh_ovf;
  logic vid_elig, cpu_elig, strobe_hold;

  sdram_rfsh_timer #(
    .PERIOD (RFSH_PERIOD)
  ) u_rfsh_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (rfsh_clr),
    .pending (rfsh_pend),
    .ovf     (rfsh_ovf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    rfsh_d    = 1'b0;
    a_d       = a_q;
    wd_d      = wd_q;
    vid_q_d   = vid_q_q;
    cpu_q_d   = cpu_q_q;
    vid_ack_d = 1'b0;
    cpu_ack_d = 1'b0;
    rfsh_clr  = 1'b0;
    // A port is masked during its own ack cycle so a held request re-grants one cycle later
    vid_elig    = bus.vid_req && !vid_ack_q;
    cpu_elig    = bus.cpu_req && !cpu_ack_q;
    strobe_hold = (32'(cnt_q) + 32'd1) < STROBE;

    case (state_q)
      ST_IDLE: begin
        if (bus.sdram_ready) begin
          if (rfsh_pend) begin
            state_d  = ST_BUSY;
            cnt_d    = '0;
            owner_d  = OWN_RFSH;
            we_d     = 1'b0;
            rfsh_d   = 1'b1;
            rfsh_clr = 1'b1;
          end else if (vid_elig) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            owner_d = OWN_VID;
            we_d    = 1'b0;
            rd_d    = 1'b1;
            a_d     = bus.vid_a;
          end else if (cpu_elig) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            owner_d = OWN_CPU;
            we_d    = bus.cpu_we;
            rd_d    = !bus.cpu_we;
            wr_d    = bus.cpu_we;
            a_d     = bus.cpu_a;
            if (bus.cpu_we) wd_d = bus.cpu_d;
          end
        end
      end
      ST_BUSY: begin
        cnt_d  = cnt_q + 1'b1;
        rd_d   = rd_q && strobe_hold;
        wr_d   = wr_q && strobe_hold;
        rfsh_d = rfsh_q && strobe_hold;
        if (cnt_q == CNT_W'(DATA_LAT) && !we_q) begin
          if (owner_q == OWN_VID) vid_q_d = bus.sdram_q;
          if (owner_q == OWN_CPU) cpu_q_d = bus.sdram_q;
        end
        if (cnt_q == CNT_W'(SLOT - 1)) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          owner_d   = OWN_NONE;
          vid_ack_d = (owner_q == OWN_VID);
          cpu_ack_d = (owner_q == OWN_CPU);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_NONE;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rfsh_q    <= 1'b0;
      a_q       <= '0;
      wd_q      <= '0;
      vid_q_q   <= '0;
      cpu_q_q   <= '0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rfsh_q    <= rfsh_d;
      a_q       <= a_d;
      wd_q      <= wd_d;
      vid_q_q   <= vid_q_d;
      cpu_q_q   <= cpu_q_d;
      vid_ack_q <= vid_ack_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  assign bus.sdram_rd   = rd_q;
  assign bus.sdram_wr   = wr_q;
  assign bus.sdram_rfsh = rfsh_q;
  assign bus.sdram_a    = a_q;
  assign bus.sdram_d    = wd_q;
  assign bus.vid_q      = vid_q_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.cpu_q      = cpu_q_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.rfsh_ovf   = rfsh_ovf;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table of client transactions plus
// hand-written sequences for priority, refresh overflow and mid-slot reset.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int STROBE      = STROBE_DFLT;
  localparam int DATA_LAT    = DATA_LAT_DFLT;
  localparam int SLOT        = SLOT_DFLT;
  localparam int RFSH_PERIOD = RFSH_PERIOD_DFLT;

  typedef struct {
    owner_e      kind;
    logic        we;
    logic [24:0] a;
    logic [15:0] d;
    logic [15:0] rdata;
  } txn_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sdram_arbiter_if bus ();

  sdram_arbiter #(
    .STROBE      (STROBE_DFLT),
    .DATA_LAT    (DATA_LAT_DFLT),
    .SLOT        (SLOT_DFLT),
    .RFSH_PERIOD (RFSH_PERIOD_DFLT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  txn_t exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference refresh period counter
  int m_cnt = 0;
  int m_wraps = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt   <= 0;
      m_wraps <= 0;
    end else if (m_cnt == RFSH_PERIOD - 1) begin
      m_cnt   <= 0;
      m_wraps <= m_wraps + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Controller model and slot monitor
  bit          active = 1'b0;
  int          c = 0;
  int          idle_c = 0;
  int          consumed = 0;
  owner_e      last_kind = OWN_NONE;
  txn_t        cur;
  logic [2:0]  prev_strb = 3'b000;
  logic [15:0] exp_vid_q = 16'h0;
  logic [15:0] exp_cpu_q = 16'h0;

  always @(negedge clock) begin
    logic [2:0] strb, rise, exp_strb;
    int w;
    if (!reset) begin
      active = 1'b0;
      consumed = 0;
      exp_vid_q = 16'h0;
      exp_cpu_q = 16'h0;
      prev_strb = 3'b000;
      bus.sdram_q = 16'hDEAD;
    end else begin
      strb = {bus.sdram_rd, bus.sdram_wr, bus.sdram_rfsh};
      rise = strb & ~prev_strb;
      if (active) c++;
      else idle_c++;
      if (active && c == SLOT) begin
        check("ack", 96'({bus.vid_ack, bus.cpu_ack}),
              96'(cur.kind == OWN_VID ? 2'b10 : cur.kind == OWN_CPU ? 2'b01 : 2'b00));
        if (cur.kind == OWN_VID && !cur.we) exp_vid_q = cur.rdata;
        if (cur.kind == OWN_CPU && !cur.we) exp_cpu_q = cur.rdata;
        check("q_hold", 96'({bus.vid_q, bus.cpu_q}), 96'({exp_vid_q, exp_cpu_q}));
        active = 1'b0;
        idle_c = 0;
        last_kind = cur.kind;
      end else if (bus.vid_ack || bus.cpu_ack) begin
        check("spurious_ack", 96'({bus.vid_ack, bus.cpu_ack}), 96'(2'b00));
      end
      if (!active && rise != 3'b000) begin
        if (rise[0]) begin
          w = m_wraps - ((m_cnt == 0) ? 1 : 0);
          check("rfsh_due", 96'(w > consumed), 96'(1));
          consumed = w;
          if (exp_q.size() != 0 && exp_q[0].kind == OWN_RFSH) void'(exp_q.pop_front());
          cur = '{OWN_RFSH, 1'b0, 25'h0, 16'h0, 16'h0};
          active = 1'b1;
          c = 0;
        end else if (exp_q.size() == 0) begin
          check("unexpected_strobe", 96'(rise), 96'(3'b000));
        end else begin
          cur = exp_q.pop_front();
          check("strobe_kind", 96'(rise),
                96'(cur.kind == OWN_RFSH ? 3'b001 : cur.we ? 3'b010 : 3'b100));
          if (cur.kind == last_kind && cur.kind != OWN_RFSH)
            check("regrant_gap", 96'(idle_c >= 2), 96'(1));
          active = 1'b1;
          c = 0;
        end
      end else if (!active && strb != 3'b000) begin
        check("idle_strobe", 96'(strb), 96'(3'b000));
      end
      if (active && c < SLOT) begin
        exp_strb = (c < STROBE) ?
                   (cur.kind == OWN_RFSH ? 3'b001 : cur.we ? 3'b010 : 3'b100) : 3'b000;
        check("strobe", 96'(strb), 96'(exp_strb));
        if (cur.kind != OWN_RFSH) check("addr", 96'(bus.sdram_a), 96'(cur.a));
        if (cur.kind == OWN_CPU && cur.we) check("wdata", 96'(bus.sdram_d), 96'(cur.d));
        if (c == DATA_LAT + 1 && cur.kind != OWN_RFSH && !cur.we)
          check("rdata", 96'(cur.kind == OWN_VID ? bus.vid_q : bus.cpu_q), 96'(cur.rdata));
      end
      bus.sdram_q = (active && c == DATA_LAT && !cur.we && cur.kind != OWN_RFSH) ?
                    cur.rdata : 16'hDEAD;
      prev_strb = strb;
    end
  end

  task automatic wait_ack(input bit vid, output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (vid ? bus.vid_ack : bus.cpu_ack) got = 1'b1;
    end
  endtask

  task automatic wait_wraps(input int target);
    for (int i = 0; i < 4 * RFSH_PERIOD && m_wraps < target; i++) @(negedge clock);
    check("wrap_wait", 96'(m_wraps >= target), 96'(1));
  endtask

  task automatic do_txn(input txn_t t);
    bit got;
    exp_q.push_back(t);
    if (t.kind == OWN_VID) begin
      bus.vid_a = t.a;
      bus.vid_req = 1'b1;
    end else begin
      bus.cpu_a = t.a;
      bus.cpu_d = t.d;
      bus.cpu_we = t.we;
      bus.cpu_req = 1'b1;
    end
    wait_ack(t.kind == OWN_VID, got);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    check("ack_wait", 96'(got), 96'(1));
  endtask

  txn_t vecs[8];

  initial begin
    bit   got;
    txn_t t;
    vecs[0] = '{OWN_VID, 1'b0, 25'h0000100, 16'h0000, 16'hA55A};
    vecs[1] = '{OWN_CPU, 1'b1, 25'h0012345, 16'hBEEF, 16'h0000};
    vecs[2] = '{OWN_CPU, 1'b0, 25'h1ABCDEF, 16'h0000, 16'h1234};
    vecs[3] = '{OWN_CPU, 1'b1, 25'h1FFFFFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{OWN_VID, 1'b0, 25'h0000000, 16'h0000, 16'hFFFF};
    vecs[5] = '{OWN_CPU, 1'b0, 25'h0000001, 16'h0000, 16'h0001};
    vecs[6] = '{OWN_VID, 1'b0, 25'h1000000, 16'h0000, 16'h8000};
    vecs[7] = '{OWN_CPU, 1'b1, 25'h0000000, 16'h0000, 16'h0000};

    reset = 1'b1;
    bus.sdram_ready = 1'b0;
    bus.vid_req = 1'b0;
    bus.vid_a = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_a = '0;
    bus.cpu_d = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 96'({bus.sdram_rd, bus.sdram_wr, bus.sdram_rfsh, bus.sdram_a,
          bus.sdram_d, bus.vid_q, bus.vid_ack, bus.cpu_q, bus.cpu_ack, bus.rfsh_ovf}), '0);
    reset = 1'b1;

    // Request held while the controller is not ready: no strobes
    bus.cpu_a = 25'h0000ABC;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check("no_grant_unready",
            96'({bus.sdram_rd, bus.sdram_wr, bus.sdram_rfsh}), 96'(3'b000));
    end
    bus.sdram_ready = 1'b1;
    do_txn('{OWN_CPU, 1'b0, 25'h0000ABC, 16'h0000, 16'h5EED});

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Pending refresh, video and CPU all requesting at once
    repeat (12) @(negedge clock);
    bus.sdram_ready = 1'b0;
    wait_wraps(m_wraps + 1);
    exp_q.push_back('{OWN_RFSH, 1'b0, 25'h0, 16'h0, 16'h0});
    exp_q.push_back('{OWN_VID, 1'b0, 25'h0AAAAAA, 16'h0, 16'h6789});
    exp_q.push_back('{OWN_CPU, 1'b0, 25'h0555555, 16'h0, 16'h9876});
    bus.vid_a = 25'h0AAAAAA;
    bus.vid_req = 1'b1;
    bus.cpu_a = 25'h0555555;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    bus.sdram_ready = 1'b1;
    wait_ack(1'b1, got);
    bus.vid_req = 1'b0;
    check("prio_vid_ack", 96'(got), 96'(1));
    wait_ack(1'b0, got);
    bus.cpu_req = 1'b0;
    check("prio_cpu_ack", 96'(got), 96'(1));

    // Refresh starved by ready low across three ticks
    @(negedge clock);
    reset = 1'b0;
    bus.sdram_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_wraps(1);
    check("ovf_after_1", 96'(bus.rfsh_ovf), 96'(0));
    wait_wraps(2);
    check("ovf_after_2", 96'(bus.rfsh_ovf), 96'(1));
    wait_wraps(3);
    exp_q.push_back('{OWN_RFSH, 1'b0, 25'h0, 16'h0, 16'h0});
    bus.sdram_ready = 1'b1;
    repeat (30) @(negedge clock);
    check("rfsh_slot_issued", 96'(exp_q.size()), 96'(0));
    check("ovf_sticky", 96'(bus.rfsh_ovf), 96'(1));

    // Reset during c=1 of a CPU read abandons the slot; request re-granted afterwards
    t = '{OWN_CPU, 1'b0, 25'h0155555, 16'h0, 16'hC3C3};
    exp_q.push_back(t);
    bus.cpu_a = t.a;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (bus.sdram_rd) got = 1'b1;
    end
    check("rd_seen", 96'(got), 96'(1));
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("rd_async_drop", 96'(bus.sdram_rd), 96'(0));
    check("reset_cpu_q", 96'({bus.cpu_ack, bus.cpu_q}), 96'(0));
    repeat (2) @(negedge clock);
    exp_q.push_back(t);
    reset = 1'b1;
    wait_ack(1'b0, got);
    bus.cpu_req = 1'b0;
    check("regrant_ack", 96'(got), 96'(1));

    repeat (5) @(negedge clock);
    check("queue_drained", 96'(exp_q.size()), 96'(0));
    check("ovf_clear", 96'(bus.rfsh_ovf), 96'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
